ifid_fetch_queue: RTL and testbench
===================================

IFID_FETCH_QUEUE -- requirements
Module: ifid_fetch_queue

Interface
REQ-001 The block SHALL have parameter INSTR_WIDTH, default 32, fetched instruction width.
REQ-002 The block SHALL have parameter PC_WIDTH, default 64, program counter width.
REQ-003 The block SHALL have parameter DEPTH, default 4, entry count, power of two, >= 2.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear (redirect or mispredict).
- enq_valid  in  1  IF offers an entry.
- enq_ready  out  1  queue accepts an entry.
- enq_instr  in  INSTR_WIDTH  fetched instruction.
- enq_pc  in  PC_WIDTH  PC of that instruction.
- enq_fault  in  1  fetch access fault flag.
- deq_valid  out  1  head entry available to ID.
- deq_ready  in  1  ID consumes the head entry.
- deq_instr  out  INSTR_WIDTH  head instruction.
- deq_pc  out  PC_WIDTH  head PC.
- deq_fault  out  1  head fault flag.
- count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-005 The block SHALL be an in-order FIFO of {instr, pc, fault} entries with DEPTH slots, read pointer, write pointer and occupancy counter.
REQ-006 Enqueue SHALL occur on a rising edge when enq_valid && enq_ready.
REQ-007 Dequeue SHALL occur on a rising edge when deq_valid && deq_ready.
REQ-008 enq_ready SHALL equal (count != DEPTH) && !flush, with no combinational path from deq_ready.
REQ-009 deq_valid SHALL equal (count != 0), except as amended by REQ-020.
REQ-010 While deq_valid is 0, deq_instr, deq_pc and deq_fault SHALL be driven to all zeros.
REQ-011 With simultaneous enqueue and dequeue, count SHALL remain unchanged and both pointers SHALL advance.
REQ-012 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-013 Enqueue-to-deq_valid latency SHALL be one cycle for an empty queue.
REQ-014 When flush is 1 at a rising edge, count and both pointers SHALL become 0, any enqueue or dequeue in that cycle SHALL be discarded, and deq_valid SHALL be 0 in the following cycle.
REQ-015 Flush SHALL take priority over every other event except reset_n.
REQ-016 Held inputs on a full queue SHALL NOT overwrite stored entries, and entries SHALL NOT be lost or duplicated.
REQ-017 deq_ready asserted while deq_valid is 0 SHALL have no effect.

Reset
REQ-018 On reset_n low, the block SHALL immediately, without waiting for clk, set count, pointers, deq_valid, deq_instr, deq_pc and deq_fault to 0, and set enq_ready to 1 once flush is 0.
REQ-019 Assertion of reset_n mid-operation SHALL discard all stored entries, and the first enqueue after release SHALL behave as on an empty queue.

Configuration
REQ-020 When macro IFIDQ_BYPASS_EN is defined, an empty queue with enq_valid high and flush low SHALL assert deq_valid in the same cycle and present enq_instr, enq_pc and enq_fault on the deq outputs.
- If deq_ready is also 1 in that cycle, the entry SHALL be consumed without being written and count SHALL stay 0.
- Otherwise the entry SHALL be written normally.
REQ-021 When IFIDQ_BYPASS_EN is undefined, no combinational path SHALL exist from the enq inputs to the deq outputs, and REQ-013 latency SHALL apply.

Verification
REQ-022 The bench SHALL cover: reset_n low with data present -> count=0, deq_valid=0, deq_instr=0 without a clock edge.
REQ-023 The bench SHALL cover: enqueue 4 entries {0x00000013, PC 0x1000..0x100C} with deq_ready=0 -> count=4, enq_ready=0, and a 5th enq_valid is ignored.
REQ-024 The bench SHALL cover: from full, deq_ready=1 for 4 cycles -> PCs 0x1000, 0x1004, 0x1008, 0x100C emitted in order, then deq_valid=0.
REQ-025 The bench SHALL cover: count=2 with enq_valid=1 and deq_ready=1 for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-026 The bench SHALL cover: count=3 with flush=1, enq_valid=1 and deq_ready=1 -> next cycle count=0, deq_valid=0, and the enqueued PC never appears.
REQ-027 The bench SHALL cover, with IFIDQ_BYPASS_EN defined: empty queue with enq_valid=1 (PC 0x2000) and deq_ready=1 -> deq_pc=0x2000 in the same cycle and count stays 0.

Source files
------------

// File: rtl/ifid_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifid_fetch_queue
// Description : In-order IF->ID instruction queue of {instr, pc, fault}
//               entries. The optional same-cycle bypass from enq to deq is
//               built in only when IFIDQ_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_fetch_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int PC_WIDTH    = 64,
  parameter int DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [INSTR_WIDTH-1:0]   enq_instr,
  input  logic [PC_WIDTH-1:0]      enq_pc,
  input  logic                     enq_fault,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [INSTR_WIDTH-1:0]   deq_instr,
  output logic [PC_WIDTH-1:0]      deq_pc,
  output logic                     deq_fault,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [INSTR_WIDTH-1:0] r_instr_mem [DEPTH];
  logic [PC_WIDTH-1:0]    r_pc_mem    [DEPTH];
  logic [DEPTH-1:0]       r_fault_mem;
  logic [AW-1:0]          r_rdptr;
  logic [AW-1:0]          r_wrptr;
  logic [CW-1:0]          r_count;

  logic w_empty;
  logic w_full;
  logic w_bypass;
  logic w_enq_fire;
  logic w_deq_fire;
  logic w_push;
  logic w_pop;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == C_FULL);
  assign enq_ready = !w_full && !flush;
  assign count     = r_count;

`ifdef IFIDQ_BYPASS_EN
  assign w_bypass = w_empty && enq_valid && !flush;
`else
  assign w_bypass = 1'b0;
`endif

  assign deq_valid  = !w_empty || w_bypass;
  assign w_enq_fire = enq_valid && enq_ready;
  assign w_deq_fire = deq_valid && deq_ready && !flush;
  // A bypassed entry that is consumed in the same cycle never touches storage.
  assign w_push     = w_enq_fire && !(w_bypass && deq_ready);
  assign w_pop      = w_deq_fire && !w_empty;

  always_comb begin
    deq_instr = '0;
    deq_pc    = '0;
    deq_fault = 1'b0;
    if (!w_empty) begin
      deq_instr = r_instr_mem[r_rdptr];
      deq_pc    = r_pc_mem[r_rdptr];
      deq_fault = r_fault_mem[r_rdptr];
    end else if (w_bypass) begin
      deq_instr = enq_instr;
      deq_pc    = enq_pc;
      deq_fault = enq_fault;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rdptr <= '0;
      r_wrptr <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_rdptr <= '0;
      r_wrptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrptr <= r_wrptr + 1'b1;
      if (w_pop)  r_rdptr <= r_rdptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is qualified by r_count, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wrptr] <= enq_instr;
      r_pc_mem[r_wrptr]    <= enq_pc;
      r_fault_mem[r_wrptr] <= enq_fault;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifid_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifid_fetch_queue
// Description : Scoreboard bench for ifid_fetch_queue with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifid_fetch_queue;

  localparam int IW = 32;
  localparam int PW = 64;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          flush;
  logic          enq_valid;
  logic          enq_ready;
  logic [IW-1:0] enq_instr;
  logic [PW-1:0] enq_pc;
  logic          enq_fault;
  logic          deq_valid;
  logic          deq_ready;
  logic [IW-1:0] deq_instr;
  logic [PW-1:0] deq_pc;
  logic          deq_fault;
  logic [2:0]    count;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [PW-1:0] pc;
    logic          fault;
  } ent_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   mon_tests = 0;
  int   mon_fail  = 0;

  ifid_fetch_queue #(.INSTR_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(D)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_instr (enq_instr),
    .enq_pc    (enq_pc),
    .enq_fault (enq_fault),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_instr (deq_instr),
    .deq_pc    (deq_pc),
    .deq_fault (deq_fault),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one entry; the caller records it as expected only if it will be taken.
  task automatic offer(input logic [PW-1:0] pc, input logic fault, input bit expect_taken);
    enq_valid = 1'b1;
    enq_instr = 32'h0000_0013;
    enq_pc    = pc;
    enq_fault = fault;
    if (expect_taken) exp_q.push_back('{instr: 32'h0000_0013, pc: pc, fault: fault});
  endtask

  // Monitor: every handshake the DUT completes must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && !flush && deq_valid && deq_ready) begin
      mon_tests++;
      if (exp_q.size() == 0) begin
        mon_fail++;
        $display("FAIL unexpected_deq: got pc 0x%0h expected no output", deq_pc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({deq_instr, deq_pc, deq_fault} !== mon_e) begin
          mon_fail++;
          $display("FAIL deq_entry: got instr 0x%0h pc 0x%0h fault %0b expected instr 0x%0h pc 0x%0h fault %0b",
                   deq_instr, deq_pc, deq_fault, mon_e.instr, mon_e.pc, mon_e.fault);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    enq_valid = 1'b0;
    enq_instr = '0;
    enq_pc    = '0;
    enq_fault = 1'b0;
    deq_ready = 1'b0;
    #3;
    check("reset_count", count, 0);
    check("reset_deq_valid", deq_valid, 0);
    check("reset_enq_ready", enq_ready, 1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Fill to full with ID stalled; fifth offer must be refused.
    for (int i = 0; i < 4; i++) begin
      offer(64'h1000 + 64'(4 * i), (i == 3), 1'b1);
`ifndef IFIDQ_BYPASS_EN
      if (i == 0) begin
        #1;
        check("latency_before_edge", deq_valid, 0);
      end
`endif
      tick();
      if (i == 0) check("latency_after_edge", deq_valid, 1);
    end
    offer(64'h1010, 1'b0, 1'b0);
    #1;
    check("full_count", count, 4);
    check("full_enq_ready", enq_ready, 0);
    check("full_head_pc", deq_pc, 64'h1000);
    tick();
    check("full_count_after_5th", count, 4);
    enq_valid = 1'b0;

    // Drain in order.
    deq_ready = 1'b1;
    repeat (4) tick();
    check("drained_deq_valid", deq_valid, 0);
    check("drained_count", count, 0);
    check("drained_deq_pc_zero", deq_pc, 0);
    check("drained_deq_instr_zero", deq_instr, 0);
    tick();
    check("empty_deq_ready_no_effect", count, 0);
    deq_ready = 1'b0;

    // Steady state at count=2 with simultaneous enq/deq; pointers wrap.
    offer(64'h3000, 1'b0, 1'b1); tick();
    offer(64'h3004, 1'b1, 1'b1); tick();
    deq_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(64'h3008 + 64'(4 * i), i[0], 1'b1);
      tick();
      check("steady_count", count, 2);
    end
    enq_valid = 1'b0;
    repeat (2) tick();
    check("steady_drained_count", count, 0);
    deq_ready = 1'b0;

    // Flush at count=3 with both handshakes offered.
    offer(64'h4000, 1'b0, 1'b1); tick();
    offer(64'h4004, 1'b0, 1'b1); tick();
    offer(64'h4008, 1'b0, 1'b1); tick();
    enq_valid = 1'b0;
    check("preflush_count", count, 3);
    flush = 1'b1;
    deq_ready = 1'b1;
    offer(64'h4ffc, 1'b1, 1'b0);
    exp_q.delete();
    #1;
    check("flush_enq_ready", enq_ready, 0);
    tick();
    flush = 1'b0;
    enq_valid = 1'b0;
    #1;
    check("postflush_count", count, 0);
    check("postflush_deq_valid", deq_valid, 0);
    repeat (3) tick();
    offer(64'h5000, 1'b0, 1'b1);
    tick();
    enq_valid = 1'b0;
    tick();
    check("postflush_drain_count", count, 0);
    deq_ready = 1'b0;

    // Asynchronous reset with data present, then a clean restart.
    offer(64'h6000, 1'b0, 1'b1); tick();
    offer(64'h6004, 1'b0, 1'b1); tick();
    enq_valid = 1'b0;
    check("prereset_count", count, 2);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset_count", count, 0);
    check("async_reset_deq_valid", deq_valid, 0);
    check("async_reset_deq_instr", deq_instr, 0);
    check("async_reset_deq_pc", deq_pc, 0);
    check("async_reset_enq_ready", enq_ready, 1);
    tick();
    reset_n = 1'b1;
    tick();
    offer(64'h7000, 1'b1, 1'b1);
`ifndef IFIDQ_BYPASS_EN
    #1;
    check("restart_latency", deq_valid, 0);
`endif
    tick();
    enq_valid = 1'b0;
    #1;
    check("restart_count", count, 1);
    check("restart_head_pc", deq_pc, 64'h7000);
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    check("restart_drained", count, 0);

`ifdef IFIDQ_BYPASS_EN
    // Same-cycle bypass into an empty queue with ID ready.
    deq_ready = 1'b1;
    offer(64'h2000, 1'b0, 1'b1);
    #1;
    check("bypass_deq_valid", deq_valid, 1);
    check("bypass_deq_pc", deq_pc, 64'h2000);
    tick();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    check("bypass_count", count, 0);
`endif

    tick();
    check("scoreboard_empty", exp_q.size(), 0);
    n_tests += mon_tests;
    n_fail  += mon_fail;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
